// File: rtl/fifo_pkg.sv
// Shared Gray/binary helpers for the async FIFO pointer controllers.
// Values are carried in a 32-bit container; callers zero-extend and slice.
package fifo_pkg;

    localparam int unsigned GW = 32;

    // Binary to reflected Gray code.
    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary, prefix XOR from the MSB down.
    // Zero-extended inputs decode correctly for any width up to GW.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Shared by both FIFO sides.
module sync_2ff #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] rq1_q;
    logic [WIDTH-1:0] rq2_q;

    // Two back-to-back flops; rq2 is the only stage used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            rq1_q <= '0;
            rq2_q <= '0;
        end else begin
            rq1_q <= d;
            rq2_q <= rq1_q;
        end
    end

    assign q = rq2_q;

endmodule

// File: rtl/write_inc.sv
// Write-side pointer and full-flag controller for the async FIFO.
// Produces the Gray write pointer and full/level/overflow status.
module write_inc
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE       = 4,
    parameter int unsigned ALMOST_FULL_TH = (1 << ADDRSIZE) - 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signal_write,
    input  logic [ADDRSIZE:0]   graycode_rptr,
    output logic                write_en,
    output logic [ADDRSIZE-1:0] write_address,
    output logic [ADDRSIZE:0]   graycode_wptr,
    output logic                full,
    output logic                almost_full,
    output logic [ADDRSIZE:0]   wr_level,
    output logic                overflow
);

    localparam int unsigned PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;

    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] full_pat;
    logic [GW-1:0] gray_w;
    logic [GW-1:0] rbin_w;
    logic          unused_hi;

    sync_2ff #(
        .WIDTH(PW)
    ) u_rsync (
        .clk(clk),
        .rst(rst),
        .d  (graycode_rptr),
        .q  (rq2)
    );

    assign write_en = signal_write & ~full_q;

    assign gray_w    = bin2gray({{(GW-PW){1'b0}}, wbin_d});
    assign rbin_w    = gray2bin({{(GW-PW){1'b0}}, rq2});
    assign unused_hi = ^{gray_w[GW-1:PW], rbin_w[GW-1:PW]};
    assign rbin_sync = rbin_w[PW-1:0];

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_pat = {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]};

    // Next pointer, level and flags; compares use the post-write pointer
    // so full rises on the edge that accepts the last free slot.
    always_comb begin
        wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, write_en};
        gray_d  = gray_w[PW-1:0];
        level_d = wbin_d - rbin_sync;
        full_d  = (gray_d == full_pat);
        af_d    = (level_d >= AF_TH);
        ovf_d   = ovf_q | (signal_write & full_q);
    end

    // State registers; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign write_address = wbin_q[ADDRSIZE-1:0];
    assign graycode_wptr = gray_q;
    assign full          = full_q;
    assign almost_full   = af_q;
    assign wr_level      = level_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_write_inc.sv
// Self-checking bench for write_inc (ADDRSIZE=4, ALMOST_FULL_TH=12).
// Reference model tracks pointers as plain integer counts.
module tb_write_inc;

    localparam int A = 4;
    localparam int D = 16;
    localparam int M = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         signal_write = 1'b0;
    logic [A:0]   graycode_rptr = '0;
    logic         write_en;
    logic [A-1:0] write_address;
    logic [A:0]   graycode_wptr;
    logic         full;
    logic         almost_full;
    logic [A:0]   wr_level;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int wtot = 0;
    int s1 = 0;
    int s2 = 0;
    int lvl = 0;
    bit mfull = 0;
    bit maf = 0;
    bit movf = 0;
    int we_cnt = 0;

    write_inc #(
        .ADDRSIZE(A),
        .ALMOST_FULL_TH(12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signal_write (signal_write),
        .graycode_rptr(graycode_rptr),
        .write_en     (write_en),
        .write_address(write_address),
        .graycode_wptr(graycode_wptr),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic int g(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("write_address", 32'(write_address), 32'(wtot % D));
        chk("graycode_wptr", 32'(graycode_wptr), 32'(g(wtot % M)));
        chk("full", 32'(full), 32'(mfull));
        chk("almost_full", 32'(almost_full), 32'(maf));
        chk("wr_level", 32'(wr_level), 32'(lvl));
        chk("overflow", 32'(overflow), 32'(movf));
    endtask

    // One clock: drive inputs, check write_en, apply edge, check outputs.
    task automatic step(input bit sw, input bit r, input int rb,
                        input bit chk_post);
        bit acc;
        @(negedge clk);
        signal_write  = sw;
        rst           = r;
        graycode_rptr = (A+1)'(g(rb % M));
        #1;
        if (!r) chk("write_en", 32'(write_en), 32'(sw && !mfull));
        if (write_en === 1'b1 && !r) we_cnt++;
        @(posedge clk);
        if (r) begin
            wtot = 0; s1 = 0; s2 = 0; lvl = 0;
            mfull = 0; maf = 0; movf = 0;
        end else begin
            acc  = sw && !mfull;
            movf = movf || (sw && mfull);
            wtot = wtot + int'(acc);
            lvl  = ((wtot % M) - s2 + M) % M;
            mfull = (lvl == D);
            maf  = (lvl >= 12);
            s2 = s1;
            s1 = rb % M;
        end
        #1;
        if (chk_post) chk_outs();
    endtask

    initial begin
        int rtot;
        int prev_g;
        bit seen10000;
        bit seen00000;

        // reset held for two edges with a pending write request
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        chk("rst_gray", 32'(graycode_wptr), 32'h0);

        // fill with a stalled reader
        we_cnt = 0;
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1);
        chk("fill_we_pulses", 32'(we_cnt), 32'd16);
        chk("fill_gray", 32'(graycode_wptr), 32'b11000);
        chk("fill_level", 32'(wr_level), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd1);

        // release by one read; visible on the third edge
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("rel_full_held", 32'(full), 32'd1);
        step(0, 0, 1, 1);
        chk("rel_full", 32'(full), 32'd0);
        chk("rel_level", 32'(wr_level), 32'd15);
        step(1, 0, 1, 1);
        chk("refull", 32'(full), 32'd1);

        // almost-full threshold
        step(0, 1, 0, 1);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 1);
        chk("af_11", 32'(almost_full), 32'd0);
        chk("lvl_11", 32'(wr_level), 32'd11);
        step(1, 0, 0, 1);
        chk("af_12", 32'(almost_full), 32'd1);
        chk("lvl_12", 32'(wr_level), 32'd12);

        // wrap with the reader trailing by three
        step(0, 1, 0, 1);
        seen10000 = 0;
        seen00000 = 0;
        prev_g = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, (wtot >= 3) ? wtot - 3 : 0, 1);
            chk("wrap_onebit", 32'($countones(32'(graycode_wptr) ^ prev_g)),
                32'd1);
            prev_g = int'(graycode_wptr);
            if (graycode_wptr == 5'b10000) seen10000 = 1;
            if (graycode_wptr == 5'b00000 && seen10000) seen00000 = 1;
            chk("wrap_full", 32'(full), 32'd0);
        end
        chk("wrap_passed", 32'({seen10000, seen00000}), 32'b11);
        chk("wrap_ovf", 32'(overflow), 32'd0);

        // fill to overflow then reset mid-operation
        rtot = wtot - 3;
        for (int i = 0; i < 22; i++) step(1, 0, rtot, 1);
        chk("mid_full", 32'(full), 32'd1);
        chk("mid_ovf", 32'(overflow), 32'd1);
        step(1, 1, rtot, 1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_addr", 32'(write_address), 32'd0);
        step(1, 0, 0, 1);
        chk("resume_addr", 32'(write_address), 32'd1);

        // randomized traffic with a legal reader
        step(0, 1, 0, 1);
        rtot = 0;
        for (int i = 0; i < 400; i++) begin
            if (rtot < wtot && $urandom_range(0, 2) == 0) rtot++;
            step(bit'($urandom_range(0, 3) != 0), 0, rtot, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
